scio_uart_tx: RTL

- Memory-mapped 8N1 UART transmitter on the single-cycle computer's data bus, in parallel with the data memory.
- Consumes the CPU store stream: address from the ALU result, store data, write-enable.
- Buffers bytes in a small FIFO and serialises them on txd with a programmable bit period.
- Read path is combinational, matching data-memory read timing, so the top can mux it into the CPU's load data.

---
 rtl/scio_pkg.sv | 17 +
 rtl/scio_fifo.sv | 39 +++
 rtl/scio_uart_tx.sv | 106 ++++++++++
 3 files changed

// File: rtl/scio_pkg.sv
// scio_pkg: register offsets, STATUS bit positions and FSM encoding for the scio UART transmitter
package scio_pkg;
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam int ST_FULL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_ACTIVE = 2;
  localparam int ST_OVF = 3;
  localparam int ST_CNT_LSB = 8;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_START = 2'd1,
    S_DATA = 2'd2,
    S_STOP = 2'd3
  } state_t;
endpackage

// File: rtl/scio_fifo.sv
// scio_fifo: synchronous FIFO; push/din write, pop/dout read head, full/empty/count flags
// A push into a full FIFO is still taken when a pop happens on the same edge.
module scio_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push_ok, pop_ok;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign pop_ok = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= din;
  always_ff @(posedge clk)
    if (clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= push_ok ? wp + AW'(1) : wp;
      rp <= pop_ok ? rp + AW'(1) : rp;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
endmodule

// File: rtl/scio_uart_tx.sv
// scio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO and programmable bit period
// Ports: clk/clr (sync active-high reset), addr/wdata/we store bus, rdata/hit combinational
// read path for the load mux, txd serial out (idle high), busy while sending or FIFO non-empty.
module scio_uart_tx
  import scio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_FF00,
  parameter int FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET = 16'd434
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        txd,
  output logic        busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [1:0] off;
  logic wr, push, pop, full, empty, overflow, unused_bits;
  logic [7:0] dout, shift;
  logic [CW-1:0] count;
  logic [15:0] divisor, div_eff, period, cnt;
  logic [2:0] bit_cnt;
  logic [31:0] status;
  state_t state;
  assign off = addr[3:2];
  assign hit = addr[31:4] == BASE_ADDR[31:4];
  assign wr = we & hit;
  assign push = wr & (off == REG_TXDATA);
  assign pop = (state == S_IDLE) & ~empty;
  assign busy = (state != S_IDLE) | ~empty;
  assign div_eff = divisor == '0 ? 16'd1 : divisor;
  assign unused_bits = ^{addr[1:0], wdata[31:16]};
  scio_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .clr(clr),
    .push(push),
    .din(wdata[7:0]),
    .pop(pop),
    .dout(dout),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_comb begin
    status = '0;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_ACTIVE] = state != S_IDLE;
    status[ST_OVF] = overflow;
    status[ST_CNT_LSB +: 4] = 4'(count);
  end
  assign rdata = !hit ? '0 : off == REG_STATUS ? status : off == REG_DIVISOR ? {16'd0, divisor} : '0;
  always_ff @(posedge clk)
    if (clr) begin
      divisor <= DIV_RESET;
      overflow <= 1'b0;
    end else begin
      if (wr && off == REG_DIVISOR) divisor <= wdata[15:0];
      if (push && full && !pop) overflow <= 1'b1;
      else if (wr && off == REG_STATUS && wdata[ST_OVF]) overflow <= 1'b0;
    end
  // cnt counts down the cycles left in the current bit; the bit ends on the edge where cnt==1.
  always_ff @(posedge clk)
    if (clr) begin
      state <= S_IDLE;
      txd <= 1'b1;
      shift <= '0;
      bit_cnt <= '0;
      period <= 16'd1;
      cnt <= 16'd1;
    end else begin
      case (state)
        S_IDLE: if (!empty) begin
          shift <= dout;
          bit_cnt <= '0;
          period <= div_eff;
          cnt <= div_eff;
          txd <= 1'b0;
          state <= S_START;
        end
        S_START: if (cnt == 16'd1) begin
          cnt <= period;
          txd <= shift[0];
          state <= S_DATA;
        end else cnt <= cnt - 16'd1;
        S_DATA: if (cnt == 16'd1) begin
          cnt <= period;
          if (bit_cnt == 3'd7) begin
            txd <= 1'b1;
            state <= S_STOP;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            shift <= shift >> 1;
            txd <= shift[1];
          end
        end else cnt <= cnt - 16'd1;
        S_STOP: if (cnt == 16'd1) state <= S_IDLE;
        else cnt <= cnt - 16'd1;
      endcase
    end
endmodule
